// File: rtl/bitvec_freelist_if.sv
// Allocation/release handshake bundle between the rename/retire clients and the tag free-list.
interface bitvec_freelist_if #(
   parameter int LG_N = 5
);
   logic            alloc_req;
   logic            alloc_valid;
   logic [LG_N-1:0] alloc_idx;
   logic            free_valid;
   logic [LG_N-1:0] free_idx;
   logic [LG_N:0]   free_count;
   logic            empty;
   logic            full;
   logic            dbl_free_err;
   logic            underflow_err;

   modport master (
      output alloc_req,
      output free_valid,
      output free_idx,
      input  alloc_valid,
      input  alloc_idx,
      input  free_count,
      input  empty,
      input  full,
      input  dbl_free_err,
      input  underflow_err
   );

   modport slave (
      input  alloc_req,
      input  free_valid,
      input  free_idx,
      output alloc_valid,
      output alloc_idx,
      output free_count,
      output empty,
      output full,
      output dbl_free_err,
      output underflow_err
   );
endinterface

// File: rtl/bitvec_freelist.sv
// Bitmap free-list of 2^LG_N tags: grants the lowest free tag, takes back one released tag per cycle.
module bitvec_freelist_lowest #(
   parameter int LG = 5
) (
   input  logic [(1<<LG)-1:0] vec,
   output logic               any,
   output logic [LG-1:0]      idx
);
   localparam int HALF = 1 << (LG - 1);

   // Lower half wins whenever it holds a set bit; otherwise the upper half's index gets the MSB.
   if (LG == 1) begin : g_leaf
      assign any = vec[0] | vec[1];
      assign idx = ~vec[0];
   end else begin : g_split
      logic          lo_any;
      logic          hi_any;
      logic [LG-2:0] lo_idx;
      logic [LG-2:0] hi_idx;

      bitvec_freelist_lowest #(.LG(LG - 1)) u_lo (
         .vec (vec[HALF-1:0]),
         .any (lo_any),
         .idx (lo_idx)
      );

      bitvec_freelist_lowest #(.LG(LG - 1)) u_hi (
         .vec (vec[2*HALF-1:HALF]),
         .any (hi_any),
         .idx (hi_idx)
      );

      assign any = lo_any | hi_any;
      assign idx = lo_any ? {1'b0, lo_idx} : {1'b1, hi_idx};
   end
endmodule

module bitvec_freelist #(
   parameter int LG_N = 5
) (
   input  logic              clk,
   input  logic              reset,
   bitvec_freelist_if.slave  bus
);
   localparam int            N          = 1 << LG_N;
   localparam logic [LG_N:0] COUNT_FULL = (LG_N + 1)'(N);
   localparam logic [LG_N:0] COUNT_ONE  = (LG_N + 1)'(1);

   logic [N-1:0]    bitmap_q;
   logic [N-1:0]    bitmap_d;
   logic [LG_N:0]   count_q;
   logic [LG_N:0]   count_d;
   logic            dbl_free_err_q;
   logic            dbl_free_err_d;
   logic            underflow_err_q;
   logic            underflow_err_d;

   logic            enc_any;
   logic [LG_N-1:0] enc_idx;
   logic            grant;
   logic            rel_ok;
   logic            free_hit;

   bitvec_freelist_lowest #(.LG(LG_N)) u_enc (
      .vec (bitmap_q),
      .any (enc_any),
      .idx (enc_idx)
   );

   // A release can only target a busy bit and a grant only a free bit, so the two never collide.
   always_comb begin
      bitmap_d        = bitmap_q;
      count_d         = count_q;
      dbl_free_err_d  = dbl_free_err_q;
      underflow_err_d = underflow_err_q;

      grant    = bus.alloc_req && enc_any;
      free_hit = bus.free_valid && bitmap_q[bus.free_idx];
      rel_ok   = bus.free_valid && !bitmap_q[bus.free_idx];

      if (grant) begin
         bitmap_d[enc_idx] = 1'b0;
      end
      if (rel_ok) begin
         bitmap_d[bus.free_idx] = 1'b1;
      end

      unique case ({rel_ok, grant})
         2'b10:   count_d = count_q + COUNT_ONE;
         2'b01:   count_d = count_q - COUNT_ONE;
         default: count_d = count_q;
      endcase

      if (free_hit) begin
         dbl_free_err_d = 1'b1;
      end
      if (bus.alloc_req && !enc_any) begin
         underflow_err_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         bitmap_q        <= '1;
         count_q         <= COUNT_FULL;
         dbl_free_err_q  <= 1'b0;
         underflow_err_q <= 1'b0;
      end else begin
         bitmap_q        <= bitmap_d;
         count_q         <= count_d;
         dbl_free_err_q  <= dbl_free_err_d;
         underflow_err_q <= underflow_err_d;
      end
   end

   assign bus.alloc_valid   = enc_any;
   assign bus.alloc_idx     = enc_idx;
   assign bus.free_count    = count_q;
   assign bus.empty         = (count_q == '0);
   assign bus.full          = (count_q == COUNT_FULL);
   assign bus.dbl_free_err  = dbl_free_err_q;
   assign bus.underflow_err = underflow_err_q;
endmodule

// File: tb/tb_bitvec_freelist.sv
// Directed and random checks of bitvec_freelist against an array-of-flags reference model.
module tb_bitvec_freelist;
   localparam int LG_N = 5;
   localparam int N    = 1 << LG_N;

   logic clk = 1'b0;
   logic reset;

   bit model_free [N];
   bit model_dbl;
   bit model_under;

   int tests_run    = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   bitvec_freelist_if #(.LG_N(LG_N)) fl_if ();

   bitvec_freelist #(.LG_N(LG_N)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (fl_if.slave)
   );

   task automatic check_val(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      tests_run++;
      assert (observed === expected) else begin
         tests_failed++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   function automatic int model_count();
      int c = 0;
      for (int i = 0; i < N; i++) c += int'(model_free[i]);
      return c;
   endfunction

   function automatic int model_lowest();
      for (int i = 0; i < N; i++) begin
         if (model_free[i]) return i;
      end
      return -1;
   endfunction

   task automatic check_output(input string tag);
      int cnt;
      int low;
      cnt = model_count();
      low = model_lowest();
      check_val({tag, ":alloc_valid"}, 32'(fl_if.alloc_valid), 32'(low >= 0));
      if (low >= 0) check_val({tag, ":alloc_idx"}, 32'(fl_if.alloc_idx), 32'(low));
      check_val({tag, ":free_count"}, 32'(fl_if.free_count), 32'(cnt));
      check_val({tag, ":empty"}, 32'(fl_if.empty), 32'(cnt == 0));
      check_val({tag, ":full"}, 32'(fl_if.full), 32'(cnt == N));
      check_val({tag, ":dbl_free_err"}, 32'(fl_if.dbl_free_err), 32'(model_dbl));
      check_val({tag, ":underflow_err"}, 32'(fl_if.underflow_err), 32'(model_under));
   endtask

   // Drive one cycle of inputs, advance the model across the edge, then idle the inputs.
   task automatic apply_stimulus(input bit rst, input bit req, input bit fv, input int fidx);
      int low;
      bit do_release;
      reset            = rst;
      fl_if.alloc_req  = req;
      fl_if.free_valid = fv;
      fl_if.free_idx   = LG_N'(fidx);
      low        = model_lowest();
      do_release = 1'b0;
      @(posedge clk);
      if (rst) begin
         for (int i = 0; i < N; i++) model_free[i] = 1'b1;
         model_dbl   = 1'b0;
         model_under = 1'b0;
      end else begin
         if (req && low < 0) model_under = 1'b1;
         if (fv) begin
            if (model_free[fidx]) model_dbl = 1'b1;
            else do_release = 1'b1;
         end
         if (req && low >= 0) model_free[low] = 1'b0;
         if (do_release) model_free[fidx] = 1'b1;
      end
      #1;
      reset            = 1'b0;
      fl_if.alloc_req  = 1'b0;
      fl_if.free_valid = 1'b0;
      fl_if.free_idx   = '0;
   endtask

   initial begin
      reset            = 1'b1;
      fl_if.alloc_req  = 1'b0;
      fl_if.free_valid = 1'b0;
      fl_if.free_idx   = '0;

      apply_stimulus(1, 0, 0, 0);
      check_output("reset");
      check_val("reset_full_const", 32'(fl_if.full), 32'd1);

      for (int i = 0; i < 4; i++) begin
         check_val("seq_grant_idx", 32'(fl_if.alloc_idx), 32'(i));
         apply_stimulus(0, 1, 0, 0);
         check_output("seq_alloc");
      end
      check_val("seq_count_const", 32'(fl_if.free_count), 32'd28);

      apply_stimulus(1, 0, 0, 0);
      for (int i = 0; i < N; i++) apply_stimulus(0, 1, 0, 0);
      check_output("drained");
      apply_stimulus(0, 1, 0, 0);
      check_output("underflow");
      check_val("underflow_const", 32'(fl_if.underflow_err), 32'd1);

      apply_stimulus(1, 0, 0, 0);
      for (int i = 0; i < 8; i++) apply_stimulus(0, 1, 0, 0);
      apply_stimulus(0, 0, 1, 3);
      check_output("free3");
      check_val("free3_idx_const", 32'(fl_if.alloc_idx), 32'd3);
      check_val("free3_count_const", 32'(fl_if.free_count), 32'd25);

      apply_stimulus(1, 0, 0, 0);
      for (int i = 0; i < 8; i++) apply_stimulus(0, 1, 0, 0);
      apply_stimulus(0, 1, 1, 5);
      check_output("grant_and_free");
      check_val("gf_count_const", 32'(fl_if.free_count), 32'd24);
      check_val("gf_idx_const", 32'(fl_if.alloc_idx), 32'd5);

      apply_stimulus(1, 0, 0, 0);
      apply_stimulus(0, 1, 1, 10);
      check_output("dbl_free");
      check_val("dbl_count_const", 32'(fl_if.free_count), 32'd31);

      apply_stimulus(1, 0, 0, 0);
      for (int i = 0; i < 20; i++) apply_stimulus(0, 1, 0, 0);
      apply_stimulus(0, 1, 1, 25);
      apply_stimulus(1, 1, 1, 3);
      check_output("reset_override");
      check_val("ro_count_const", 32'(fl_if.free_count), 32'd32);

      for (int n = 0; n < 500; n++) begin
         apply_stimulus($urandom_range(0, 99) < 2, $urandom_range(0, 3) != 0,
                        $urandom_range(0, 2) == 0, int'($urandom_range(0, N - 1)));
         check_output("random");
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
